regfile: RTL

REGFILE -- requirements
Module: regfile

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_if.sv | 29 ++
 rtl/regfile.sv | 84 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared CPU constants for the register file, destination mux and controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: default widths, architectural register indices, destination-select encoding.
package regfile_pkg;

  // Default datapath geometry for the CPU core.
  localparam int CPU_DATA_W = 32;
  localparam int CPU_ADDR_W = 5;

  // Architectural register indices with fixed meaning.
  localparam logic [CPU_ADDR_W-1:0] REG_ZERO = 5'd0;   // hard-wired zero
  localparam logic [CPU_ADDR_W-1:0] REG_RA   = 5'd31;  // link register (jal target)

  // 2-bit select of the destination mux that drives the write index.
  typedef enum logic [1:0] {
    DST_RD  = 2'd0,
    DST_RT  = 2'd1,
    DST_RA  = 2'd2,
    DST_ALT = 2'd3
  } dest_sel_e;

endpackage

// File: rtl/regfile_if.sv
// Bundle of the register-file write port, two read ports, debug port and write counter.
// Latency: reads are combinational; writes land on the next rising clk edge.
// Backpressure: none; the register file accepts a write every cycle.
// Modports: master drives indices/write data and observes read data; slave is the register file.
interface regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [15:0]       wr_count;

  modport master (
    output we, waddr, wdata, raddr1, raddr2, dbg_addr,
    input  rdata1, rdata2, dbg_data, wr_count
  );

  modport slave (
    input  we, waddr, wdata, raddr1, raddr2, dbg_addr,
    output rdata1, rdata2, dbg_data, wr_count
  );
endinterface

// File: rtl/regfile.sv
// 2**ADDR_W x DATA_W register file, index 0 reads zero, optional write-to-read forwarding.
// Latency: zero-cycle combinational reads; writes commit on the rising clk edge.
// Backpressure: none; one write and three reads are serviced every cycle.
// Ports: clk, rst (sync, active-high), bus (regfile_if.slave: we/waddr/wdata, raddr1/rdata1,
//        raddr2/rdata2, dbg_addr/dbg_data, wr_count = committed non-zero-index writes, wraps).
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  // Plain flop array; the forwarding muxes sit outside it so the array
  // itself stays a simple write-port/read-port memory.
  logic [DATA_W-1:0] regs [DEPTH];
  logic [15:0]       wr_count_q;
  logic              wr_commit;

  // A write is real only when enabled, not aimed at the zero register and
  // not swallowed by reset. The short-circuit on we keeps an X/Z index
  // from leaking into the commit decision when the port is idle.
  assign wr_commit = bus.we && !rst && (bus.waddr != ZERO_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      wr_count_q <= '0;
    end else if (wr_commit) begin
      regs[bus.waddr] <= bus.wdata;
      wr_count_q      <= wr_count_q + 16'd1;
    end
  end

  // One read port: index 0 is forced to zero independent of the array
  // contents, then the pending write is forwarded when enabled and matching.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] stored,
    input logic              commit,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd,
    input logic              fwd_en
  );
    logic [DATA_W-1:0] val;
    val = stored;
    if (fwd_en && commit && (ra == wa)) begin
      val = wd;
    end
    if (ra == ZERO_IDX) begin
      val = '0;
    end
    return val;
  endfunction

  logic [DATA_W-1:0] rdata1_c;
  logic [DATA_W-1:0] rdata2_c;
  logic [DATA_W-1:0] dbg_data_c;

  always_comb begin
    rdata1_c   = read_port(bus.raddr1, regs[bus.raddr1], wr_commit,
                           bus.waddr, bus.wdata, BYPASS != 0);
    rdata2_c   = read_port(bus.raddr2, regs[bus.raddr2], wr_commit,
                           bus.waddr, bus.wdata, BYPASS != 0);
    // Trace port shows architectural state only, so forwarding is off.
    dbg_data_c = read_port(bus.dbg_addr, regs[bus.dbg_addr], wr_commit,
                           bus.waddr, bus.wdata, 1'b0);
  end

  assign bus.rdata1   = rdata1_c;
  assign bus.rdata2   = rdata2_c;
  assign bus.dbg_data = dbg_data_c;
  assign bus.wr_count = wr_count_q;

endmodule
